// File: rtl/fifo_ctrl_flags.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ctrl_flags
// Description : Pointer and flag controller for a circular buffer held in an
//               external dual-port RAM. Produces RAM addresses, qualified
//               write/read strobes, full/empty, almost-full/almost-empty and
//               a registered occupancy count. Overflow/underflow attempts are
//               rejected without disturbing state.
//               Optional macro FIFO_CTRL_ERR_STICKY_EN adds sticky
//               overflow/underflow error flags with an err_clr input.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ctrl_flags #(
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 2**ADDR_WIDTH - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef FIFO_CTRL_ERR_STICKY_EN
    input  logic                  err_clr,
`endif
    input  logic                  wr,
    input  logic                  rd,
    output logic                  w_en,
    output logic                  r_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
`ifdef FIFO_CTRL_ERR_STICKY_EN
    output logic                  overflow,
    output logic                  underflow,
`endif
    output logic [ADDR_WIDTH:0]   count
);

    // Thresholds and increment sized to the pointer/count width.
    localparam logic [ADDR_WIDTH:0] c_af_level = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] c_ae_level = (ADDR_WIDTH+1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH:0] c_one      = (ADDR_WIDTH+1)'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_WIDTH:0] r_wr_ptr;
    logic [ADDR_WIDTH:0] r_rd_ptr;
    logic [ADDR_WIDTH:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;

    // Flags derive purely from registered pointers; strobes gate requests with them.
    always_comb begin
        w_empty  = (r_wr_ptr == r_rd_ptr);
        w_full   = (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]) &&
                   (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]);
        w_wr_acc = wr & ~w_full;
        w_rd_acc = rd & ~w_empty;
    end

    assign w_en         = w_wr_acc;
    assign r_en         = w_rd_acc;
    assign full         = w_full;
    assign empty        = w_empty;
    assign w_addr       = r_wr_ptr[ADDR_WIDTH-1:0];
    assign r_addr       = r_rd_ptr[ADDR_WIDTH-1:0];
    assign count        = r_count;
    assign almost_full  = (r_count >= c_af_level);
    assign almost_empty = (r_count <= c_ae_level);

    // Advance pointers on accepted ops and track occupancy; reset discards contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_one;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_one;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + c_one;
                2'b01:   r_count <= r_count - c_one;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef FIFO_CTRL_ERR_STICKY_EN
    // Sticky error flags: a new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr && w_full) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (rd && w_empty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_ctrl_flags.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_ctrl_flags
// Description : Self-checking bench for fifo_ctrl_flags, ADDR_WIDTH=3
//               (DEPTH=8, AF_LEVEL=7, AE_LEVEL=1). Table-driven vectors plus
//               hand-written fill/drain and error-flag sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_ctrl_flags;

    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr = 1'b0;
    logic          rd = 1'b0;
    logic          w_en;
    logic          r_en;
    logic [AW-1:0] w_addr;
    logic [AW-1:0] r_addr;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
`ifdef FIFO_CTRL_ERR_STICKY_EN
    logic          err_clr = 1'b0;
    logic          overflow;
    logic          underflow;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    fifo_ctrl_flags #(
        .ADDR_WIDTH (AW),
        .AF_LEVEL   (7),
        .AE_LEVEL   (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
`ifdef FIFO_CTRL_ERR_STICKY_EN
        .err_clr      (err_clr),
`endif
        .wr           (wr),
        .rd           (rd),
        .w_en         (w_en),
        .r_en         (r_en),
        .w_addr       (w_addr),
        .r_addr       (r_addr),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
`ifdef FIFO_CTRL_ERR_STICKY_EN
        .overflow     (overflow),
        .underflow    (underflow),
`endif
        .count        (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rst;
        bit       wr;
        bit       rd;
        bit       ew;      // expected w_en before the edge
        bit       er;      // expected r_en before the edge
        int       cnt;     // expected state after the edge
        bit       fl;
        bit       em;
        bit       af;
        bit       ae;
        int       wa;
        int       ra;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive inputs, let them settle, then advance one clock and sample after the edge.
    task automatic cyc(input bit w, input bit r);
        wr = w;
        rd = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input int cnt, input bit fl, input bit em,
                             input bit af, input bit ae, input int wa, input int ra);
        chk({tag, ".count"}, int'(count), cnt);
        chk({tag, ".full"}, int'(full), int'(fl));
        chk({tag, ".empty"}, int'(empty), int'(em));
        chk({tag, ".almost_full"}, int'(almost_full), int'(af));
        chk({tag, ".almost_empty"}, int'(almost_empty), int'(ae));
        chk({tag, ".w_addr"}, int'(w_addr), wa);
        chk({tag, ".r_addr"}, int'(r_addr), ra);
    endtask

    initial begin
        //                rst wr rd ew er cnt fl em af ae wa ra
        vq.push_back('{0, 1, 1, 1, 0, 1, 0, 0, 0, 1, 1, 0}); // empty, wr&rd: write only
        vq.push_back('{0, 1, 0, 1, 0, 2, 0, 0, 0, 0, 2, 0});
        vq.push_back('{0, 1, 0, 1, 0, 3, 0, 0, 0, 0, 3, 0});
        vq.push_back('{0, 1, 0, 1, 0, 4, 0, 0, 0, 0, 4, 0});
        vq.push_back('{0, 1, 0, 1, 0, 5, 0, 0, 0, 0, 5, 0});
        vq.push_back('{0, 1, 0, 1, 0, 6, 0, 0, 0, 0, 6, 0});
        vq.push_back('{0, 1, 0, 1, 0, 7, 0, 0, 1, 0, 7, 0}); // almost_full from 7
        vq.push_back('{0, 1, 0, 1, 0, 8, 1, 0, 1, 0, 0, 0}); // full, w_addr wrapped
        vq.push_back('{0, 1, 0, 0, 0, 8, 1, 0, 1, 0, 0, 0}); // write on full rejected
        vq.push_back('{0, 1, 1, 0, 1, 7, 0, 0, 1, 0, 0, 1}); // full, wr&rd: read only
        vq.push_back('{0, 1, 1, 1, 1, 7, 0, 0, 1, 0, 1, 2}); // both accepted
        vq.push_back('{0, 0, 1, 0, 1, 6, 0, 0, 0, 0, 1, 3});
        vq.push_back('{0, 0, 1, 0, 1, 5, 0, 0, 0, 0, 1, 4});
        vq.push_back('{0, 0, 1, 0, 1, 4, 0, 0, 0, 0, 1, 5});
        vq.push_back('{0, 0, 1, 0, 1, 3, 0, 0, 0, 0, 1, 6});
        vq.push_back('{0, 0, 1, 0, 1, 2, 0, 0, 0, 0, 1, 7});
        vq.push_back('{0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 1, 0}); // r_addr wraps, almost_empty
        vq.push_back('{0, 0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1}); // drained
        vq.push_back('{0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 1, 1}); // read on empty rejected
        vq.push_back('{0, 1, 0, 1, 0, 1, 0, 0, 0, 1, 2, 1}); // one entry
        vq.push_back('{1, 1, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0}); // reset overrides wr

        // Initial reset, then idle three cycles and check the reset state.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) cyc(0, 0);
        chk_state("idle", 0, 0, 1, 0, 1, 0, 0);
        chk("idle.w_en", int'(w_en), 0);
        chk("idle.r_en", int'(r_en), 0);

        // Table-driven vectors.
        for (int i = 0; i < vq.size(); i++) begin
            reset = vq[i].rst;
            wr    = vq[i].wr;
            rd    = vq[i].rd;
            #1;
            chk($sformatf("v%0d.w_en", i), int'(w_en), int'(vq[i].ew));
            chk($sformatf("v%0d.r_en", i), int'(r_en), int'(vq[i].er));
            @(posedge clk);
            #1;
            chk_state($sformatf("v%0d", i), vq[i].cnt, vq[i].fl, vq[i].em,
                      vq[i].af, vq[i].ae, vq[i].wa, vq[i].ra);
        end
        reset = 1'b0;

        // Fill to 8, reject a ninth write, then drain checking the read address order.
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fill%0d.w_addr", i), int'(w_addr), i);
            cyc(1, 0);
            chk($sformatf("fill%0d.almost_full", i), int'(almost_full), (i + 1 >= 7) ? 1 : 0);
        end
        wr = 1'b1;
        #1;
        chk("ninth.w_en", int'(w_en), 0);
        cyc(1, 0);
        chk_state("ninth", 8, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d.r_addr", i), int'(r_addr), i);
            cyc(0, 1);
            chk($sformatf("drain%0d.almost_empty", i), int'(almost_empty), (7 - i <= 1) ? 1 : 0);
        end
        cyc(0, 0);
        chk_state("drained", 0, 0, 1, 0, 1, 0, 0);

`ifdef FIFO_CTRL_ERR_STICKY_EN
        // Sticky error flags.
        chk("err.init_underflow", int'(underflow), 0);
        cyc(0, 1);
        chk("err.underflow_set", int'(underflow), 1);
        cyc(0, 0);
        chk("err.underflow_held", int'(underflow), 1);
        err_clr = 1'b1;
        cyc(0, 0);
        err_clr = 1'b0;
        chk("err.underflow_clr", int'(underflow), 0);
        err_clr = 1'b1;
        cyc(0, 1);
        err_clr = 1'b0;
        chk("err.set_beats_clr", int'(underflow), 1);
        chk("err.overflow_quiet", int'(overflow), 0);
        for (int i = 0; i < 8; i++) cyc(1, 0);
        chk("err.overflow_before", int'(overflow), 0);
        cyc(1, 0);
        chk("err.overflow_set", int'(overflow), 1);
        reset = 1'b1;
        cyc(0, 0);
        reset = 1'b0;
        chk("err.reset_overflow", int'(overflow), 0);
        chk("err.reset_underflow", int'(underflow), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
